spike_weight_fetch_sched: RTL and testbench

- Sequences reads of one synaptic-weight block RAM for an SNN layer.
- Accepts presynaptic spike indices into a small FIFO. For each spike it streams the NUM_POST weights of that presynaptic row to the neuron-update datapath, tagged with the post-neuron index.
- Sits between the spike router and the weight BRAM; it is the only driver of the BRAM enable and address.

---
 rtl/spike_weight_fetch_sched.sv | 187 ++++++++++++++++++
 tb/tb_spike_weight_fetch_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_weight_fetch_sched.sv
// rtl/spike_weight_fetch_sched.sv - queues presynaptic spikes and streams each spike's weight row from BRAM
// Each row is NUM_POST weights; the output stream carries the (pre, post) tag of every weight.
module spike_weight_fetch_sched #(
   parameter int NUM_PRE           = 64,
   parameter int NUM_POST          = 16,
   parameter int BRAM_ADDR_WIDTH   = 10,
   parameter int FIXED_POINT_WIDTH = 32,
   parameter int FIFO_DEPTH        = 8,
   localparam int PRE_W  = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1,
   localparam int POST_W = (NUM_POST > 1) ? $clog2(NUM_POST) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                spike_valid,
   input  logic [PRE_W-1:0]                    spike_idx,
   output logic                                spike_ready,
   input  logic                                tstep_end,
   output logic                                tstep_done,
   output logic                                bram_en,
   output logic [BRAM_ADDR_WIDTH-1:0]          bram_addr,
   input  logic signed [FIXED_POINT_WIDTH-1:0] bram_data,
   output logic                                w_valid,
   input  logic                                w_ready,
   output logic signed [FIXED_POINT_WIDTH-1:0] w_data,
   output logic [POST_W-1:0]                   w_post_idx,
   output logic [PRE_W-1:0]                    w_pre_idx,
   output logic                                spike_err
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   generate
      if (NUM_PRE * NUM_POST > 2 ** BRAM_ADDR_WIDTH) begin : g_bad_addr
         $error("NUM_PRE*NUM_POST exceeds the BRAM address space");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of two and at least 2");
      end
   endgenerate

   typedef enum logic {IDLE, FETCH} state_t;

   state_t                         state;
   logic [PRE_W-1:0]               fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]               wr_ptr;
   logic [PTR_W-1:0]               rd_ptr;
   logic [CNT_W-1:0]               fifo_count;
   logic [PRE_W-1:0]               cur_pre;
   logic [POST_W-1:0]              j;
   logic                           inflight;
   logic [PRE_W-1:0]               tag_pre;
   logic [POST_W-1:0]              tag_post;
   logic signed [FIXED_POINT_WIDTH-1:0] buf_data [2];
   logic [PRE_W-1:0]               buf_pre [2];
   logic [POST_W-1:0]              buf_post [2];
   logic                           buf_rd;
   logic                           buf_wr;
   logic [1:0]                     buf_count;
   logic                           pending;

   logic                           idx_ok;
   logic                           push;
   logic                           pop;
   logic                           fifo_empty;
   logic                           w_pop;
   logic [1:0]                     buf_eff;
   logic                           issue;
   logic                           last_issue;
   logic                           pend_eff;
   logic                           all_idle;

   // Extra bit keeps the range test meaningful when NUM_PRE is a power of two.
   assign idx_ok      = {1'b0, spike_idx} < (PRE_W + 1)'(NUM_PRE);
   assign spike_ready = fifo_count < CNT_W'(FIFO_DEPTH);
   assign push        = spike_valid && spike_ready && idx_ok;
   assign fifo_empty  = (fifo_count == '0);

   assign w_valid    = (buf_count != 2'd0);
   assign w_data     = buf_data[buf_rd];
   assign w_pre_idx  = buf_pre[buf_rd];
   assign w_post_idx = buf_post[buf_rd];
   assign w_pop      = w_valid && w_ready;
   assign buf_eff    = buf_count - {1'b0, w_pop};

   // Reads in flight plus buffered weights never exceed the two buffer slots.
   assign issue      = (state == FETCH) && (({1'b0, buf_eff} + {2'b00, inflight}) < 3'd2);
   assign last_issue = issue && (j == POST_W'(NUM_POST - 1));
   assign pop        = !fifo_empty && ((state == IDLE) || last_issue);
   assign bram_en    = issue;

   always_comb begin
      bram_addr = '0;
      if (issue)
         bram_addr = BRAM_ADDR_WIDTH'(cur_pre) * BRAM_ADDR_WIDTH'(NUM_POST) + BRAM_ADDR_WIDTH'(j);
   end

   assign pend_eff = pending || tstep_end;
   assign all_idle = (state == IDLE) && fifo_empty && !push && !inflight && (buf_eff == 2'd0);

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= spike_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         cur_pre     <= '0;
         j           <= '0;
         inflight    <= 1'b0;
         tag_pre     <= '0;
         tag_post    <= '0;
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         buf_pre[0]  <= '0;
         buf_pre[1]  <= '0;
         buf_post[0] <= '0;
         buf_post[1] <= '0;
         buf_rd      <= 1'b0;
         buf_wr      <= 1'b0;
         buf_count   <= 2'd0;
         pending     <= 1'b0;
         tstep_done  <= 1'b0;
         spike_err   <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
         if (spike_valid && spike_ready && !idx_ok)
            spike_err <= 1'b1;

         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cur_pre <= fifo_mem[rd_ptr];
                  j       <= '0;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               if (issue) begin
                  j <= j + 1'b1;
                  if (last_issue) begin
                     j <= '0;
                     if (!fifo_empty)
                        cur_pre <= fifo_mem[rd_ptr];
                     else
                        state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // The BRAM answers one cycle after issue; the tag travels alongside.
         inflight <= issue;
         if (issue) begin
            tag_pre  <= cur_pre;
            tag_post <= j;
         end
         if (inflight) begin
            buf_data[buf_wr] <= bram_data;
            buf_pre[buf_wr]  <= tag_pre;
            buf_post[buf_wr] <= tag_post;
            buf_wr           <= ~buf_wr;
         end
         if (w_pop)
            buf_rd <= ~buf_rd;
         buf_count <= buf_count + {1'b0, inflight} - {1'b0, w_pop};

         if (pend_eff && all_idle) begin
            tstep_done <= 1'b1;
            pending    <= 1'b0;
         end else begin
            tstep_done <= 1'b0;
            pending    <= pend_eff;
         end
      end
   end

endmodule

// File: tb/tb_spike_weight_fetch_sched.sv
// tb/tb_spike_weight_fetch_sched.sv - directed and randomized checks of spike_weight_fetch_sched
// BRAM holds mem[a] = a, so every weight is predicted as pre*NUM_POST + post.
module tb_spike_weight_fetch_sched;

   localparam int NUM_PRE  = 48;
   localparam int NUM_POST = 4;
   localparam int AW       = 10;
   localparam int FPW      = 32;
   localparam int DEPTH    = 8;
   localparam int PRE_W    = 6;
   localparam int POST_W   = 2;
   localparam int WORD_W   = PRE_W + POST_W + FPW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  spike_valid;
   logic [PRE_W-1:0]      spike_idx;
   logic                  spike_ready;
   logic                  tstep_end;
   logic                  tstep_done;
   logic                  bram_en;
   logic [AW-1:0]         bram_addr;
   logic signed [FPW-1:0] bram_data;
   logic                  w_valid;
   logic                  w_ready;
   logic signed [FPW-1:0] w_data;
   logic [POST_W-1:0]     w_post_idx;
   logic [PRE_W-1:0]      w_pre_idx;
   logic                  spike_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int outstanding = 0;
   int n_spk_acc = 0;
   int n_issue   = 0;
   logic [WORD_W-1:0] exp_q[$];
   int                addr_q[$];
   int                acc_cyc[$];
   int                done_cyc[$];
   logic              prev_hold = 1'b0;
   logic [WORD_W:0]   prev_word;

   spike_weight_fetch_sched #(
      .NUM_PRE(NUM_PRE), .NUM_POST(NUM_POST), .BRAM_ADDR_WIDTH(AW),
      .FIXED_POINT_WIDTH(FPW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .spike_valid(spike_valid), .spike_idx(spike_idx),
      .spike_ready(spike_ready), .tstep_end(tstep_end), .tstep_done(tstep_done),
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_data(bram_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_post_idx(w_post_idx), .w_pre_idx(w_pre_idx), .spike_err(spike_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bram_en) bram_data <= FPW'(bram_addr);

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      n_checks++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_one(int idx);
      spike_valid = 1'b1;
      spike_idx   = PRE_W'(idx);
      tick(1);
      spike_valid = 1'b0;
   endtask

   task automatic wait_idle(string tag);
      int i = 0;
      while ((exp_q.size() != 0 || w_valid) && i < 300) begin
         tick(1);
         i++;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   function automatic int span();
      if (acc_cyc.size() == 0) return -1;
      return acc_cyc[acc_cyc.size() - 1] - acc_cyc[0];
   endfunction

   // Scoreboard: every accepted in-range spike expands into NUM_POST ordered reads and weights.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         addr_q.delete();
         outstanding = 0;
         prev_hold   = 1'b0;
      end else begin
         if (tstep_done) begin
            done_cyc.push_back(cyc);
            chk("done_with_work_left", exp_q.size(), 0);
         end
         if (spike_valid && spike_ready) begin
            n_spk_acc++;
            if (int'(spike_idx) < NUM_PRE)
               for (int p = 0; p < NUM_POST; p++) begin
                  exp_q.push_back({spike_idx, POST_W'(p), FPW'(int'(spike_idx) * NUM_POST + p)});
                  addr_q.push_back(int'(spike_idx) * NUM_POST + p);
               end
         end
         if (bram_en) begin
            n_issue++;
            chk("issue_without_work", addr_q.size() > 0, 1);
            if (addr_q.size() > 0) chk("bram_addr", bram_addr, addr_q.pop_front());
            outstanding++;
         end
         if (prev_hold) chk("hold_stable", {w_valid, w_pre_idx, w_post_idx, w_data}, prev_word);
         if (w_valid && w_ready) begin
            chk("accept_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("w_word", {w_pre_idx, w_post_idx, w_data}, exp_q.pop_front());
            outstanding--;
            acc_cyc.push_back(cyc);
         end
         if (bram_en) chk("outstanding_max2", outstanding <= 2, 1);
         prev_hold = w_valid && !w_ready;
         prev_word = {w_valid, w_pre_idx, w_post_idx, w_data};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n0, i0, t0;
      rst = 1'b1; spike_valid = 1'b0; spike_idx = '0; tstep_end = 1'b0; w_ready = 1'b0;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_spike_ready", spike_ready, 1);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_tstep_done", tstep_done, 0);
      chk("rst_spike_err", spike_err, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_w_idx", {w_pre_idx, w_post_idx}, 0);

      // single row with latency measurement
      tick(1);
      w_ready = 1'b1;
      acc_cyc.delete();
      push_one(2);
      lat = -1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (w_valid && lat < 0) lat = k;
      end
      chk("first_latency", lat, 3);
      wait_idle("row2_drain");
      chk("row2_count", acc_cyc.size(), 4);
      chk("row2_span", span(), 3);

      // back-to-back rows
      acc_cyc.delete();
      push_one(1);
      push_one(3);
      wait_idle("b2b_drain");
      chk("b2b_count", acc_cyc.size(), 8);
      chk("b2b_span", span(), 7);

      // consumer stall mid-row
      acc_cyc.delete();
      push_one(5);
      for (int i = 0; i < 20 && acc_cyc.size() < 2; i++) tick(1);
      chk("stall_prefix", acc_cyc.size(), 2);
      w_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         if (s >= 2) begin
            chk("stall_bram_en", bram_en, 0);
            chk("stall_w_valid", w_valid, 1);
         end
         tick(1);
      end
      w_ready = 1'b1;
      wait_idle("stall_drain");
      chk("stall_count", acc_cyc.size(), 4);

      // fill the spike FIFO while the consumer is blocked
      w_ready = 1'b0;
      n0 = n_spk_acc;
      spike_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         spike_idx = PRE_W'($urandom_range(0, NUM_PRE - 1));
         tick(1);
      end
      spike_valid = 1'b0;
      @(negedge clk);
      chk("fill_ready_low", spike_ready, 0);
      chk("fill_accepted", n_spk_acc - n0, DEPTH + 1);
      tick(1);
      w_ready = 1'b1;
      wait_idle("fill_drain");
      @(negedge clk);
      chk("fill_ready_back", spike_ready, 1);

      // out-of-range spike
      tick(1);
      chk("err_before", spike_err, 0);
      n0 = n_spk_acc;
      i0 = n_issue;
      push_one(50);
      tick(10);
      chk("oor_handshake", n_spk_acc - n0, 1);
      chk("oor_no_reads", n_issue - i0, 0);
      chk("oor_err", spike_err, 1);

      // timestep end during a row, repeated while pending
      done_cyc.delete();
      acc_cyc.delete();
      push_one(7);
      tick(1);
      tstep_end = 1'b1; tick(1); tstep_end = 1'b0;
      tick(1);
      tstep_end = 1'b1; tick(1); tstep_end = 1'b0;
      wait_idle("ts_row_drain");
      tick(3);
      chk("ts_row_done_once", done_cyc.size(), 1);
      if (done_cyc.size() > 0 && acc_cyc.size() > 0)
         chk("ts_row_done_time", done_cyc[0] - acc_cyc[acc_cyc.size() - 1], 1);
      chk("err_sticky", spike_err, 1);

      // timestep end while idle
      done_cyc.delete();
      tstep_end = 1'b1;
      t0 = cyc;
      tick(1);
      tstep_end = 1'b0;
      tick(3);
      chk("ts_idle_done_once", done_cyc.size(), 1);
      if (done_cyc.size() > 0) chk("ts_idle_done_time", done_cyc[0] - t0, 1);

      // timestep end together with a spike: the spike belongs to this timestep
      done_cyc.delete();
      acc_cyc.delete();
      tstep_end = 1'b1;
      push_one(11);
      tstep_end = 1'b0;
      wait_idle("ts_push_drain");
      tick(3);
      chk("ts_push_done_once", done_cyc.size(), 1);
      if (done_cyc.size() > 0 && acc_cyc.size() > 0)
         chk("ts_push_done_time", done_cyc[0] - acc_cyc[acc_cyc.size() - 1], 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         spike_valid = ($urandom_range(0, 2) == 0);
         spike_idx   = PRE_W'($urandom_range(0, 63));
         w_ready     = ($urandom_range(0, 3) != 0);
         tstep_end   = ($urandom_range(0, 15) == 0);
         tick(1);
      end
      spike_valid = 1'b0;
      tstep_end = 1'b0;
      w_ready = 1'b1;
      wait_idle("random_drain");
      tick(3);

      // reset in the middle of a row
      w_ready = 1'b0;
      push_one(9);
      tick(4);
      @(negedge clk);
      chk("pre_rst_valid", w_valid, 1);
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_w_valid", w_valid, 0);
      chk("mid_rst_bram_en", bram_en, 0);
      chk("mid_rst_spike_err", spike_err, 0);
      chk("mid_rst_spike_ready", spike_ready, 1);
      chk("mid_rst_w_data", w_data, 0);
      for (int k = 0; k < 4; k++) begin
         tick(1);
         @(negedge clk);
         chk("post_rst_quiet", {w_valid, bram_en, tstep_done}, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
